cbcmac_des_arbiter: RTL and testbench
=====================================

// Module: cbcmac_des_arbiter
// PURPOSE
//  Shares one cbcmac_des core between two message requesters. Grants the core per
//  whole message (round-robin), forwards key/data blocks, issues start_i on the first
//  block, discards intermediate chaining outputs and returns only the final MAC to
//  the owning requester. Sits between requester logic and the cbcmac_des instance.
// PARAMETERS
//  LEN_W   8   width of message length field (blocks per message, 1..2**LEN_W-1)
// PORTS
//  clk_i          in   1       clock; all logic on rising edge
//  reset_i        in   1       synchronous, active-high reset
//  req_i          in   2       per-requester message request (level, held until gnt_o)
//  req_len_i      in   2*LEN_W message length in 64-bit blocks, [r*LEN_W +: LEN_W]
//  req_key_i      in   2*64    DES key per requester, sampled with first block
//  req_data_i     in   2*64    data block per requester
//  req_valid_i    in   2       block valid per requester
//  req_accept_o   out  2       block accepted (valid&accept = transfer)
//  gnt_o          out  2       one-hot; high from grant until MAC accepted
//  mac_o          out  64      final MAC of owner's message
//  mac_valid_o    out  2       MAC valid, only owner's bit set
//  mac_accept_i   in   2       requester accepts MAC
//  core_start_o / core_key_o[0:63] / core_data_o[0:63] / core_valid_o   out  to cbcmac_des
//  core_accept_i  in   1       cbcmac_des accept_o
//  core_data_i    in   64      cbcmac_des data_o (chaining value per block)
//  core_valid_i   in   1       cbcmac_des valid_o
//  core_accept_o  out  1       to cbcmac_des accept_i
// BEHAVIOUR
//  - Reset: state IDLE, gnt_o=0, req_accept_o=0, mac_valid_o=0, mac_o=0,
//    core_start_o=0, core_valid_o=0, core_key_o=0, core_data_o=0, core_accept_o=0,
//    priority pointer=requester 0, counters=0. Reset mid-message aborts it silently;
//    core is reset by system reset, not by this block.
//  - All transfers: valid&accept in same cycle; valids never depend on accepts.
//  - FSM IDLE: if any req_i, pick winner (pointer first, else other); next cycle
//    gnt_o[win]=1, len latched (len 0 treated as 1), in_cnt=out_cnt=0 -> FEED.
//  - FEED: core_valid_o=req_valid_i[own]; core_data_o=req_data_i[own];
//    req_accept_o[own]=core_accept_i (combinational pass-through, zero latency).
//    On in_cnt==0 block: core_start_o=1, core_key_o=req_key_i[own]; else start=0, key=0.
//    Each transfer in_cnt++; after len-th transfer -> DRAIN (no further accepts).
//  - Output side, in FEED and DRAIN: core_accept_o=1; each core_valid_i beat out_cnt++;
//    beats with out_cnt<len-1 discarded; beat out_cnt==len-1 captured into mac_o
//    -> DELIVER (from either state; last output cannot precede last input).
//  - DELIVER: core_accept_o=0, mac_valid_o[own]=1, mac_o stable; on mac_accept_i[own]
//    gnt_o=0, pointer=other requester, -> IDLE. Back-to-back grant earliest 1 cycle later.
//  - Non-owner: req_accept_o=0, mac_valid_o=0 always; its req_i may rise/fall freely.
//  - Owner dropping req_i mid-message ignored; message runs to completion.
//  - Both req_i same cycle: pointer wins; alternates strictly under contention.
//  - Counters LEN_W bits; no wrap since len <= 2**LEN_W-1.
// TESTING
//  1 req0, len 4, key 0123456789abcdef, blocks of data_input.txt -> one mac_valid_o[0],
//    mac_o = data_output.txt[3]; core_start_o high only on block 0; 3 beats discarded.
//  2 req0 and req1 same cycle, both len 2 -> gnt_o=01 first, then 10; second MAC
//    independent of first; third concurrent pair granted 01 (alternation holds).
//  3 len 1 message -> start and final on same block; mac_o = single DES(key,block).
//  4 req_len_i=0 -> behaves identically to len 1.
//  5 hold mac_accept_i=0 for 10 cycles -> mac_o/mac_valid_o stable, core_accept_o=0,
//    req1 pending not granted until accept.
//  6 reset_i pulsed during FEED block 2 -> next cycle all outputs at reset values,
//    new request completes with correct MAC.

Source files
------------

// File: rtl/cbcmac_des_arbiter.sv
// Round-robin arbiter sharing one cbcmac_des core between two message requesters.
// Grants per whole message, forwards blocks, and returns only the final MAC.
module cbcmac_des_arbiter #(
    parameter int unsigned LEN_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [1:0]         req_i,
    input  logic [2*LEN_W-1:0] req_len_i,
    input  logic [127:0]       req_key_i,
    input  logic [127:0]       req_data_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_accept_o,
    output logic [1:0]         gnt_o,
    output logic [63:0]        mac_o,
    output logic [1:0]         mac_valid_o,
    input  logic [1:0]         mac_accept_i,
    output logic               core_start_o,
    output logic [0:63]        core_key_o,
    output logic [0:63]        core_data_o,
    output logic               core_valid_o,
    input  logic               core_accept_i,
    input  logic [63:0]        core_data_i,
    input  logic               core_valid_i,
    output logic               core_accept_o
);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDeliver} state_e;

    state_e             state_q, state_d;
    logic               own_q, own_d;
    logic               ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
    logic [63:0]        mac_q, mac_d;

    logic               win;
    logic [LEN_W-1:0]   win_len;
    logic               own_valid;
    logic [63:0]        own_data;
    logic [63:0]        own_key;

    assign own_valid = own_q ? req_valid_i[1]       : req_valid_i[0];
    assign own_data  = own_q ? req_data_i[127:64]   : req_data_i[63:0];
    assign own_key   = own_q ? req_key_i[127:64]    : req_key_i[63:0];
    assign win       = req_i[ptr_q] ? ptr_q : ~ptr_q;
    assign win_len   = win ? req_len_i[2*LEN_W-1:LEN_W] : req_len_i[LEN_W-1:0];
    assign mac_o     = mac_q;

    always_comb begin
        state_d       = state_q;
        own_d         = own_q;
        ptr_d         = ptr_q;
        len_d         = len_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        mac_d         = mac_q;
        gnt_o         = 2'b00;
        req_accept_o  = 2'b00;
        mac_valid_o   = 2'b00;
        core_start_o  = 1'b0;
        core_key_o    = '0;
        core_data_o   = '0;
        core_valid_o  = 1'b0;
        core_accept_o = 1'b0;

        if (state_q != StIdle) begin
            gnt_o[own_q] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    own_d     = win;
                    len_d     = (win_len == '0) ? LEN_W'(1) : win_len;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = StFeed;
                end
            end
            StFeed, StDrain: begin
                if (state_q == StFeed) begin
                    core_valid_o         = own_valid;
                    core_data_o          = own_data;
                    req_accept_o[own_q]  = core_accept_i;
                    if (in_cnt_q == '0 && own_valid) begin
                        core_start_o = 1'b1;
                        core_key_o   = own_key;
                    end
                    if (own_valid && core_accept_i) begin
                        in_cnt_d = in_cnt_q + LEN_W'(1);
                        if (in_cnt_q == len_q - LEN_W'(1)) begin
                            state_d = StDrain;
                        end
                    end
                end
                // Intermediate chaining values are consumed and dropped; only the last is kept.
                core_accept_o = 1'b1;
                if (core_valid_i) begin
                    out_cnt_d = out_cnt_q + LEN_W'(1);
                    if (out_cnt_q == len_q - LEN_W'(1)) begin
                        mac_d   = core_data_i;
                        state_d = StDeliver;
                    end
                end
            end
            StDeliver: begin
                mac_valid_o[own_q] = 1'b1;
                if (mac_accept_i[own_q]) begin
                    ptr_d   = ~own_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            own_q     <= 1'b0;
            ptr_q     <= 1'b0;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            mac_q     <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            mac_q     <= mac_d;
        end
    end

endmodule

// File: tb/tb_cbcmac_des_arbiter.sv
// Randomized bench for cbcmac_des_arbiter with a stand-in chaining core and a
// transaction-level reference model of grants, transfers and MAC delivery.
module tb_cbcmac_des_arbiter;
    localparam int LEN_W = 8;

    logic               clk = 1'b0;
    logic               reset_i;
    logic [1:0]         req_i;
    logic [2*LEN_W-1:0] req_len_i;
    logic [127:0]       req_key_i;
    logic [127:0]       req_data_i;
    logic [1:0]         req_valid_i;
    logic [1:0]         req_accept_o;
    logic [1:0]         gnt_o;
    logic [63:0]        mac_o;
    logic [1:0]         mac_valid_o;
    logic [1:0]         mac_accept_i;
    logic               core_start_o;
    logic [0:63]        core_key_o;
    logic [0:63]        core_data_o;
    logic               core_valid_o;
    logic               core_accept_i;
    logic [63:0]        core_data_i;
    logic               core_valid_i;
    logic               core_accept_o;

    always #5 clk = ~clk;

    cbcmac_des_arbiter #(.LEN_W(LEN_W)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .req_len_i(req_len_i),
        .req_key_i(req_key_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
        .req_accept_o(req_accept_o), .gnt_o(gnt_o), .mac_o(mac_o), .mac_valid_o(mac_valid_o),
        .mac_accept_i(mac_accept_i), .core_start_o(core_start_o), .core_key_o(core_key_o),
        .core_data_o(core_data_o), .core_valid_o(core_valid_o), .core_accept_i(core_accept_i),
        .core_data_i(core_data_i), .core_valid_i(core_valid_i), .core_accept_o(core_accept_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Stand-in for one DES step; any keyed mixing works since the arbiter never inspects it.
    function automatic logic [63:0] mix(input logic [63:0] x, input logic [63:0] k);
        logic [63:0] t;
        t = x ^ k;
        t = {t[50:0], t[63:51]} + (k ^ 64'h9e3779b97f4a7c15);
        t = t ^ {t[31:0], t[63:32]};
        return t;
    endfunction

    // Requesters
    bit               rq_act [2];
    bit               rq_gnt [2];
    int               rq_n   [2];
    int               rq_idx [2];
    logic [LEN_W-1:0] rq_raw [2];
    logic [63:0]      rq_key [2];
    logic [63:0]      rq_exp [2];
    logic [63:0]      rq_blk [2][8];
    bit               auto_on  = 0;
    bit               hold_mac = 0;

    // Core stand-in
    typedef struct {logic [63:0] d; int rdy;} beat_t;
    beat_t       cq[$];
    logic [63:0] c_chain, c_key;
    int          c_last_rdy;
    int          starts, beats_out, done_cnt;
    int          cyc;

    // Reference model of the arbiter
    bit          m_busy, m_done;
    int          m_own, m_ptr, m_len, m_in, m_out;
    logic [63:0] m_mac;
    logic [1:0]  e_gnt, e_racc, e_mvalid;
    logic        e_cvalid, e_start, e_cacc;
    logic [63:0] e_cdata, e_key;

    logic [1:0]  gq[$];
    logic [1:0]  prev_gnt;

    task automatic reset_model();
        m_busy = 0; m_done = 0; m_own = 0; m_ptr = 0; m_len = 0; m_in = 0; m_out = 0;
        m_mac = '0;
        cq.delete(); c_chain = '0; c_key = '0; c_last_rdy = 0;
        for (int r = 0; r < 2; r++) begin rq_act[r] = 0; rq_gnt[r] = 0; end
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (auto_on && !rq_act[r] && $urandom_range(0, 3) == 0)
                start_int(r, $urandom_range(0, 7), {$urandom, $urandom});
            req_i[r] = rq_act[r] && (!rq_gnt[r] || ($urandom_range(0, 1) == 1));
            req_len_i[r*LEN_W +: LEN_W] = rq_act[r] ? rq_raw[r] : LEN_W'($urandom);
            req_key_i[r*64 +: 64] = rq_act[r] ? rq_key[r] : {$urandom, $urandom};
            req_valid_i[r] = rq_act[r] && rq_gnt[r] && rq_idx[r] < rq_n[r] &&
                             $urandom_range(0, 2) != 0;
            req_data_i[r*64 +: 64] = (rq_act[r] && rq_idx[r] < rq_n[r]) ?
                                     rq_blk[r][rq_idx[r]] : {$urandom, $urandom};
            mac_accept_i[r] = hold_mac ? 1'b0 : 1'($urandom_range(0, 1));
        end
        core_accept_i = $urandom_range(0, 3) != 0;
        core_valid_i  = cq.size() > 0 && cq[0].rdy <= cyc;
        core_data_i   = core_valid_i ? cq[0].d : {$urandom, $urandom};
    endtask

    task automatic start_int(input int r, input int rawlen, input logic [63:0] key);
        logic [63:0] chain;
        rq_act[r] = 1; rq_gnt[r] = 0; rq_idx[r] = 0; rq_key[r] = key;
        rq_raw[r] = LEN_W'(rawlen);
        rq_n[r]   = (rawlen == 0) ? 1 : rawlen;
        chain = '0;
        for (int i = 0; i < rq_n[r]; i++) begin
            rq_blk[r][i] = {$urandom, $urandom};
            chain = mix(chain ^ rq_blk[r][i], key);
        end
        rq_exp[r] = chain;
    endtask

    task automatic start_msg(input int r, input int rawlen, input logic [63:0] key);
        start_int(r, rawlen, key);
        drive();
    endtask

    task automatic compare();
        bit feeding;
        feeding  = m_busy && !m_done && m_in < m_len;
        e_gnt    = m_busy ? (2'b01 << m_own) : 2'b00;
        e_cvalid = feeding ? req_valid_i[m_own] : 1'b0;
        e_cdata  = feeding ? req_data_i[m_own*64 +: 64] : '0;
        e_start  = feeding && m_in == 0 && e_cvalid;
        e_key    = e_start ? req_key_i[m_own*64 +: 64] : '0;
        e_racc   = feeding ? ((2'b01 << m_own) & {2{core_accept_i}}) : 2'b00;
        e_cacc   = m_busy && !m_done;
        e_mvalid = m_done ? (2'b01 << m_own) : 2'b00;
        chk("gnt_o", 64'(gnt_o), 64'(e_gnt));
        chk("req_accept_o", 64'(req_accept_o), 64'(e_racc));
        chk("core_valid_o", 64'(core_valid_o), 64'(e_cvalid));
        chk("core_data_o", core_data_o, e_cdata);
        chk("core_start_o", 64'(core_start_o), 64'(e_start));
        chk("core_key_o", core_key_o, e_key);
        chk("core_accept_o", 64'(core_accept_o), 64'(e_cacc));
        chk("mac_valid_o", 64'(mac_valid_o), 64'(e_mvalid));
        chk("mac_o", mac_o, m_mac);
    endtask

    task automatic advance();
        int rdy;
        cyc++;
        if (reset_i) begin
            reset_model();
            return;
        end
        if (e_cvalid && core_accept_i) begin
            if (e_start) begin c_key = e_key; c_chain = '0; starts++; end
            c_chain = mix(c_chain ^ e_cdata, c_key);
            rdy = cyc + $urandom_range(0, 3);
            if (rdy < c_last_rdy) rdy = c_last_rdy;
            c_last_rdy = rdy;
            cq.push_back('{d: c_chain, rdy: rdy});
        end
        if (core_valid_i && e_cacc) begin
            void'(cq.pop_front());
            beats_out++;
        end
        for (int r = 0; r < 2; r++) begin
            if (rq_act[r]) begin
                if (e_gnt[r]) rq_gnt[r] = 1;
                if (req_valid_i[r] && e_racc[r]) rq_idx[r]++;
                if (e_mvalid[r] && mac_accept_i[r]) begin
                    chk("mac_end_to_end", mac_o, rq_exp[r]);
                    rq_act[r] = 0;
                    done_cnt++;
                end
            end
        end
        if (!m_busy) begin
            if (req_i != 2'b00) begin
                m_own  = req_i[m_ptr] ? m_ptr : 1 - m_ptr;
                m_len  = int'(req_len_i[m_own*LEN_W +: LEN_W]);
                if (m_len == 0) m_len = 1;
                m_in   = 0; m_out = 0; m_busy = 1;
            end
        end else if (!m_done) begin
            if (m_in < m_len && req_valid_i[m_own] && core_accept_i) m_in++;
            if (core_valid_i) begin
                m_out++;
                if (m_out == m_len) begin m_done = 1; m_mac = core_data_i; end
            end
        end else if (mac_accept_i[m_own]) begin
            m_busy = 0; m_done = 0; m_ptr = 1 - m_own;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        advance();
        @(posedge clk);
        #1;
        drive();
        if (gnt_o != 2'b00 && prev_gnt == 2'b00) gq.push_back(gnt_o);
        prev_gnt = gnt_o;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((rq_act[0] || rq_act[1] || m_busy) && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", 64'(k < budget), 64'd1);
    endtask

    initial begin
        int k, s0, b0;
        logic [63:0] snap;
        reset_i = 1; req_i = 0; req_len_i = 0; req_key_i = 0; req_data_i = 0;
        req_valid_i = 0; mac_accept_i = 0; core_accept_i = 0; core_data_i = 0;
        core_valid_i = 0; cyc = 0; starts = 0; beats_out = 0; done_cnt = 0; prev_gnt = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        drive();
        reset_i = 0;
        chk("reset_gnt", 64'(gnt_o), 64'd0);
        chk("reset_mac_valid", 64'(mac_valid_o), 64'd0);
        chk("reset_core_valid", 64'(core_valid_o), 64'd0);
        chk("reset_mac", mac_o, 64'd0);

        // Contention: two concurrent pairs must alternate 01,10,01,10.
        start_msg(0, 2, {$urandom, $urandom});
        start_msg(1, 2, {$urandom, $urandom});
        wait_idle(400);
        start_msg(0, 2, {$urandom, $urandom});
        start_msg(1, 2, {$urandom, $urandom});
        wait_idle(400);
        chk("grant_count", 64'(gq.size()), 64'd4);
        if (gq.size() >= 3) begin
            chk("grant_first", 64'(gq[0]), 64'h1);
            chk("grant_second", 64'(gq[1]), 64'h2);
            chk("grant_third", 64'(gq[2]), 64'h1);
        end

        // Four-block message: one start, four core beats, three discarded.
        s0 = starts; b0 = beats_out;
        start_msg(0, 4, 64'h0123456789abcdef);
        wait_idle(400);
        chk("len4_starts", 64'(starts - s0), 64'd1);
        chk("len4_beats", 64'(beats_out - b0), 64'd4);

        // Length 1 and length 0 both give a single block.
        b0 = beats_out;
        start_msg(0, 1, {$urandom, $urandom});
        wait_idle(400);
        chk("len1_beats", 64'(beats_out - b0), 64'd1);
        b0 = beats_out;
        start_msg(1, 0, {$urandom, $urandom});
        wait_idle(400);
        chk("len0_beats", 64'(beats_out - b0), 64'd1);

        // MAC held unaccepted: outputs frozen, pending requester kept waiting.
        hold_mac = 1;
        start_msg(0, 3, {$urandom, $urandom});
        step();
        start_msg(1, 2, {$urandom, $urandom});
        k = 0;
        while (mac_valid_o[0] !== 1'b1 && k < 400) begin step(); k++; end
        chk("hold_reach", 64'(mac_valid_o), 64'h1);
        snap = mac_o;
        repeat (10) begin
            step();
            chk("hold_mac_o", mac_o, snap);
            chk("hold_mac_valid", 64'(mac_valid_o), 64'h1);
            chk("hold_core_accept", 64'(core_accept_o), 64'd0);
            chk("hold_gnt", 64'(gnt_o), 64'h1);
        end
        hold_mac = 0;
        wait_idle(400);

        // Reset while block 2 is being fed.
        start_msg(0, 5, {$urandom, $urandom});
        k = 0;
        while (rq_idx[0] < 2 && k < 400) begin step(); k++; end
        chk("reach_block2", 64'(rq_idx[0]), 64'd2);
        reset_i = 1;
        step();
        reset_i = 0;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_req_accept", 64'(req_accept_o), 64'd0);
        chk("rst_mac_valid", 64'(mac_valid_o), 64'd0);
        chk("rst_mac", mac_o, 64'd0);
        chk("rst_core_start", 64'(core_start_o), 64'd0);
        chk("rst_core_valid", 64'(core_valid_o), 64'd0);
        chk("rst_core_key", core_key_o, 64'd0);
        chk("rst_core_data", core_data_o, 64'd0);
        chk("rst_core_accept", 64'(core_accept_o), 64'd0);
        b0 = done_cnt;
        start_msg(1, 3, {$urandom, $urandom});
        wait_idle(400);
        chk("post_reset_done", 64'(done_cnt - b0), 64'd1);

        // Free-running random traffic.
        auto_on = 1;
        repeat (4000) step();
        auto_on = 0;
        wait_idle(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
